// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data with a starvation counter that
// forces a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_if_gnt,
  output logic o_d_gnt
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    starved  = (cnt_q == LIMIT);
    o_if_gnt = 1'b0;
    o_d_gnt  = 1'b0;
    cnt_d    = cnt_q;

    // Grants are gated by reset so the whole command path reads zero
    // while reset is held, without waiting for a clock edge.
    if (i_rst_n) begin
      o_if_gnt = i_if_req && (!i_d_req || starved);
      o_d_gnt  = i_d_req && !o_if_gnt;
    end

    if (o_if_gnt || !i_if_req) begin
      cnt_d = '0;
    end else if (!starved) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data access; routes the 1-cycle read response back to whoever issued it.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,

  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  input  logic        i_if_flush,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,

  input  logic        i_d_req,
  input  logic        i_d_wen,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [3:0]  i_d_mask,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,

  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic [31:0] i_mem_rdata
);

  logic   if_gnt, d_gnt;
  owner_e owner_q, owner_d;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_if_req(i_if_req),
    .i_d_req (i_d_req),
    .o_if_gnt(if_gnt),
    .o_d_gnt (d_gnt)
  );

  assign o_if_gnt = if_gnt;
  assign o_d_gnt  = d_gnt;

  always_comb begin
    o_mem_addr  = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;

    if (if_gnt) begin
      o_mem_addr = i_if_addr;
      o_mem_ren  = 1'b1;
      o_mem_mask = 4'b1111;
    end else if (d_gnt) begin
      o_mem_addr = i_d_addr;
      if (i_d_wen) begin
        o_mem_wen   = 1'b1;
        o_mem_wdata = i_d_wdata;
        o_mem_mask  = i_d_mask;
      end else begin
        o_mem_ren  = 1'b1;
        o_mem_mask = 4'b1111;
      end
    end
  end

  // A fetch granted during a flush is a stale redirect target: drop it.
  always_comb begin
    owner_d = OWN_NONE;
    if (if_gnt && !i_if_flush) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !i_d_wen) begin
      owner_d = OWN_D;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign o_if_rvalid = (owner_q == OWN_IF) && !i_if_flush;
  assign o_d_rvalid  = (owner_q == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive conflict cycles the data port may win before fetch is forced.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port i_if_req, input, 1: instruction fetch read request.
REQ-005 SHALL have port i_if_addr, input, 32: fetch byte address.
REQ-006 SHALL have port i_if_flush, input, 1: discards any fetch response still outstanding (redirect).
REQ-007 SHALL have port o_if_gnt, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have port o_if_rvalid, output, 1: fetch read data valid.
REQ-009 SHALL have port o_if_rdata, output, 32: fetch read data.
REQ-010 SHALL have port i_d_req, input, 1: data access request.
REQ-011 SHALL have port i_d_wen, input, 1: data access is a write (1) or a read (0).
REQ-012 SHALL have ports i_d_addr (input, 32), i_d_wdata (input, 32) and i_d_mask (input, 4): data address, write data and byte mask.
REQ-013 SHALL have ports o_d_gnt (output, 1), o_d_rvalid (output, 1) and o_d_rdata (output, 32): data accept, read valid and read data.
REQ-014 SHALL have ports o_mem_addr (output, 32), o_mem_ren (output, 1), o_mem_wen (output, 1), o_mem_wdata (output, 32) and o_mem_mask (output, 4): commands to the unified memory.
REQ-015 SHALL have port i_mem_rdata, input, 32: memory read data, valid one cycle after o_mem_ren.

Function
REQ-016 SHALL share one synchronous single-port memory (1-cycle read latency, little-endian, byte-masked writes) between fetch and data; at most one command per cycle.
REQ-017 SHALL grant combinationally in the same cycle as the request and drive o_mem_* from the granted port in that cycle.
REQ-018 SHALL hold o_mem_ren, o_mem_wen and both gnt signals at 0 when no request is present.
REQ-019 Conflict (both req high): data SHALL win unless the starvation counter equals STARVE_LIMIT, in which case fetch SHALL win.
REQ-020 Starvation counter SHALL increment (saturating at STARVE_LIMIT) on each conflict cycle data wins, and clear whenever fetch is granted or i_if_req is low.
REQ-021 Requesters SHALL hold req, addr, wdata and mask stable until gnt; arbiter behaviour is undefined otherwise.
REQ-022 Fetch grant SHALL drive o_mem_ren=1, o_mem_mask=4'b1111 and o_mem_addr=i_if_addr.
REQ-023 Data read grant SHALL drive o_mem_ren=1; data write grant SHALL drive o_mem_wen=1 with wdata/mask passed through; both SHALL drive o_mem_addr=i_d_addr.
REQ-024 Owner register SHALL record {NONE, IF, D} for the read granted in cycle N; in cycle N+1 the owner's rvalid SHALL be 1 and its rdata SHALL equal i_mem_rdata.
REQ-025 Writes SHALL produce no rvalid; the owner SHALL be NONE after a write or idle cycle.
REQ-026 Back-to-back grants (one per cycle, including alternating owners) SHALL be supported with no bubble.
REQ-027 i_if_flush high SHALL force o_if_rvalid=0 in that cycle and SHALL clear an IF owner being set in that cycle; a fetch granted in the same cycle as the flush SHALL also be dropped.
REQ-028 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.

Reset
REQ-029 On i_rst_n low, SHALL immediately set owner to NONE and the starvation counter to 0 and drive all outputs to 0, independent of i_clk.
REQ-030 A read outstanding when reset asserts SHALL be discarded; no rvalid SHALL follow deassertion.

Structure
REQ-031 Package mem_arb_pkg SHALL hold the owner enum (OWN_NONE, OWN_IF, OWN_D) and the STARVE_LIMIT default constant.
REQ-032 Grant selection plus the starvation counter SHALL form one sub-module, mem_arb_prio; the muxing and the owner register SHALL stay in mem_arbiter.

Verification
REQ-033 Fetch-only read of 0x10 holding 0xDEADBEEF -> o_if_gnt=1 same cycle; next cycle o_if_rvalid=1, o_if_rdata=0xDEADBEEF; o_d_rvalid=0.
REQ-034 Both requests held continuously, STARVE_LIMIT=4 -> data granted 4 cycles, fetch granted 5th, counter cleared, then data again.
REQ-035 Data write 0x000000AA mask 0001 to 0x20, then data read 0x20 -> o_mem_wen then o_mem_ren on consecutive cycles; o_d_rvalid=1 with low byte 0xAA one cycle later; no o_if_rvalid.
REQ-036 Fetch granted at cycle N, i_if_flush at N+1 -> o_if_rvalid=0 at N+1; a data read granted at N+1 returns at N+2 unaffected.
REQ-037 i_rst_n low mid-clock with a read outstanding -> all outputs 0 before the next edge; no rvalid after release; first post-reset conflict grants data.
